ir_keypad_ctrl: RTL and testbench

Parametrised key-to-IR-command controller between the per-key debouncers and ir_encoder. It maps N debounced keys to N programmable 32-bit commands and issues each command over a valid/ready handshake. While a key is held, it issues NEC-style repeat frames after a hold delay and then at a fixed period. It replaces the hard-wired four-key command mux and the level-driven valid used so far.

---
 rtl/ir_pkg.sv | 25 ++
 rtl/ir_prio_enc.sv | 23 ++
 rtl/ir_keypad_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ir_keypad_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared types and constants for the IR keypad command path.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    HOLD,
    SEND_RPT,
    WAIT_REL
  } state_e;

  // NEC repeat spacing (108 ms) at a 25 MHz clock
  localparam int unsigned NEC_REPEAT_CYC = 2700000;

  localparam logic [31:0] CMD_RIGHT = 32'h00FF_C23D;
  localparam logic [31:0] CMD_UP    = 32'h00FF_629D;
  localparam logic [31:0] CMD_DOWN  = 32'h00FF_A857;
  localparam logic [31:0] CMD_LEFT  = 32'h00FF_22DD;

  // Index width for n items, never narrower than one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ir_prio_enc.sv
// Lowest-index-wins priority encoder with an any-set flag.
module ir_prio_enc #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  // Scan high to low so the lowest set bit is the last one written
  always_comb begin
    idx_c = '0;
    any_c = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_c = IW'(i);
        any_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ir_keypad_ctrl.sv
// Maps debounced key presses to programmable IR commands over valid/ready,
// issuing NEC-style repeat requests while the serviced key stays held.
module ir_keypad_ctrl
  import ir_pkg::*;
#(
  parameter int unsigned               NUM_KEYS      = 4,
  parameter int unsigned               CMD_W         = 32,
  parameter logic [NUM_KEYS*CMD_W-1:0] CMD_TABLE     = '0,
  parameter int unsigned               REPEAT_DELAY  = NEC_REPEAT_CYC,
  parameter int unsigned               REPEAT_PERIOD = NEC_REPEAT_CYC,
  parameter int unsigned               REPEAT_EN     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_KEYS-1:0]           key_state,
  input  logic [NUM_KEYS-1:0]           key_pressed,
  output logic [CMD_W-1:0]              cmd,
  output logic                          cmd_repeat,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [idx_w(NUM_KEYS)-1:0]    active_key,
  output logic                          busy
);

  localparam int unsigned AK_W  = idx_w(NUM_KEYS);
  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              cmd_repeat_q, cmd_repeat_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [AK_W-1:0]   active_key_q, active_key_d;
  logic              busy_q, busy_d;

  logic [AK_W-1:0]   press_idx_c;
  logic              press_any_c;
  logic              xfer_c;
  logic              held_c;
  logic [CMD_W-1:0]  cmd_tbl_c [NUM_KEYS];

  ir_prio_enc #(
    .N  (NUM_KEYS),
    .IW (AK_W)
  ) u_prio (
    .req   (key_pressed),
    .idx_c (press_idx_c),
    .any_c (press_any_c)
  );

  always_comb begin
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      cmd_tbl_c[i] = CMD_TABLE[i*CMD_W +: CMD_W];
    end
  end

  assign xfer_c = cmd_valid_q & cmd_ready;
  assign held_c = key_state[active_key_q];

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    cmd_repeat_d = cmd_repeat_q;
    cmd_valid_d  = cmd_valid_q;
    active_key_d = active_key_q;

    unique case (state_q)
      IDLE: begin
        if (press_any_c) begin
          cmd_d        = cmd_tbl_c[press_idx_c];
          cmd_repeat_d = 1'b0;
          active_key_d = press_idx_c;
          cmd_valid_d  = 1'b1;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (xfer_c) begin
          cmd_valid_d = 1'b0;
          if ((REPEAT_EN != 0) && held_c) begin
            // A one-cycle delay re-requests straight away, skipping HOLD
            if (DELAY_LD == '0) begin
              cmd_repeat_d = 1'b1;
              cmd_valid_d  = 1'b1;
              state_d      = SEND_RPT;
            end else begin
              cnt_d   = DELAY_LD;
              state_d = HOLD;
            end
          end else begin
            state_d = WAIT_REL;
          end
        end
      end
      HOLD: begin
        if (!held_c) begin
          state_d = WAIT_REL;
        end else if (cnt_q <= CNT_W'(1)) begin
          cmd_repeat_d = 1'b1;
          cmd_valid_d  = 1'b1;
          state_d      = SEND_RPT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SEND_RPT: begin
        if (xfer_c) begin
          cmd_valid_d  = 1'b0;
          cmd_repeat_d = 1'b0;
          if (held_c) begin
            if (PERIOD_LD == '0) begin
              cmd_repeat_d = 1'b1;
              cmd_valid_d  = 1'b1;
            end else begin
              cnt_d   = PERIOD_LD;
              state_d = HOLD;
            end
          end else begin
            state_d = WAIT_REL;
          end
        end
      end
      WAIT_REL: begin
        if (key_state == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cmd_q        <= '0;
      cmd_repeat_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      active_key_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      cmd_repeat_q <= cmd_repeat_d;
      cmd_valid_q  <= cmd_valid_d;
      active_key_q <= active_key_d;
      busy_q       <= busy_d;
    end
  end

  assign cmd        = cmd_q;
  assign cmd_repeat = cmd_repeat_q;
  assign cmd_valid  = cmd_valid_q;
  assign active_key = active_key_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ir_keypad_ctrl.sv
// Randomised and directed checks of ir_keypad_ctrl against a timestamp-based
// behavioural model, run on a repeat-enabled and a repeat-disabled instance.
module tb_ir_keypad_ctrl;
  import ir_pkg::*;

  localparam int D = 10;
  localparam int P = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_state = '0;
  logic [3:0]  key_pressed = '0;
  logic        cmd_ready = 1'b1;

  logic [31:0] cmd1, cmd0;
  logic        rpt1, rpt0, vld1, vld0, busy1, busy0;
  logic [1:0]  ak1, ak0;

  always #5 clk = ~clk;

  ir_keypad_ctrl #(
    .NUM_KEYS(4), .CMD_W(32),
    .CMD_TABLE({CMD_LEFT, CMD_DOWN, CMD_UP, CMD_RIGHT}),
    .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .key_state(key_state), .key_pressed(key_pressed),
    .cmd(cmd1), .cmd_repeat(rpt1), .cmd_valid(vld1), .cmd_ready(cmd_ready),
    .active_key(ak1), .busy(busy1)
  );

  ir_keypad_ctrl #(
    .NUM_KEYS(4), .CMD_W(32),
    .CMD_TABLE({CMD_LEFT, CMD_DOWN, CMD_UP, CMD_RIGHT}),
    .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .REPEAT_EN(0)
  ) dut_ne (
    .clk(clk), .rst(rst), .key_state(key_state), .key_pressed(key_pressed),
    .cmd(cmd0), .cmd_repeat(rpt0), .cmd_valid(vld0), .cmd_ready(cmd_ready),
    .active_key(ak0), .busy(busy0)
  );

  // Model: pending request plus a "next repeat due at cycle" timestamp
  typedef struct packed {
    bit          busy;
    bit          valid;
    bit          rpt;
    bit          armed;
    int          k;
    logic [31:0] cmd;
    longint      due;
  } mdl_t;

  typedef struct {
    longint      n;
    bit          rpt;
    logic [31:0] cmd;
    int          k;
  } xfer_t;

  logic [31:0] tbl [4];
  mdl_t   m1, m0;
  xfer_t  q1[$], q0[$];
  longint cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;
  bit     chk_en = 1'b0;

  function automatic mdl_t step(input mdl_t m, input bit r_i, input bit en,
                                input logic [3:0] ks, input logic [3:0] kp,
                                input bit rdy, input longint n);
    mdl_t r;
    bit   held;
    r = m;
    if (r_i) begin
      r = '0;
      return r;
    end
    if (!m.busy) begin
      if (kp != 4'b0) begin
        for (int i = 3; i >= 0; i--) if (kp[i]) r.k = i;
        r.busy  = 1'b1;
        r.valid = 1'b1;
        r.rpt   = 1'b0;
        r.armed = 1'b0;
        r.cmd   = tbl[r.k];
      end
      return r;
    end
    held = ks[m.k];
    if (!m.valid && !m.armed) begin
      if (ks == 4'b0) r.busy = 1'b0;
      return r;
    end
    if (m.valid) begin
      if (!rdy) return r;
      r.valid = 1'b0;
      r.rpt   = 1'b0;
      if (en && held) begin
        r.armed = 1'b1;
        r.due   = n + longint'(m.rpt ? P : D);
      end
    end
    if (r.armed) begin
      if (!held) r.armed = 1'b0;
      else if (n + 1 >= r.due) begin
        r.armed = 1'b0;
        r.valid = 1'b1;
        r.rpt   = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Log transfers and advance the model on every active edge
  always @(posedge clk) begin
    xfer_t e;
    if (!rst && vld1 && cmd_ready) begin
      e.n = cyc; e.rpt = rpt1; e.cmd = cmd1; e.k = int'(ak1);
      q1.push_back(e);
    end
    if (!rst && vld0 && cmd_ready) begin
      e.n = cyc; e.rpt = rpt0; e.cmd = cmd0; e.k = int'(ak0);
      q0.push_back(e);
    end
    m1 = step(m1, rst, 1'b1, key_state, key_pressed, cmd_ready, cyc);
    m0 = step(m0, rst, 1'b0, key_state, key_pressed, cmd_ready, cyc);
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid",      64'(vld1),  64'(m1.valid));
      chk("repeat",     64'(rpt1),  64'(m1.rpt));
      chk("cmd",        64'(cmd1),  64'(m1.cmd));
      chk("active_key", 64'(ak1),   64'(m1.k[1:0]));
      chk("busy",       64'(busy1), 64'(m1.busy));
      chk("ne_valid",   64'(vld0),  64'(m0.valid));
      chk("ne_repeat",  64'(rpt0),  64'(m0.rpt));
      chk("ne_cmd",     64'(cmd0),  64'(m0.cmd));
      chk("ne_key",     64'(ak0),   64'(m0.k[1:0]));
      chk("ne_busy",    64'(busy0), 64'(m0.busy));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    longint     p;
    logic [3:0] ks_prev;
    tbl[0] = CMD_RIGHT; tbl[1] = CMD_UP; tbl[2] = CMD_DOWN; tbl[3] = CMD_LEFT;
    m1 = '0;
    m0 = '0;
    cycles(3);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_valid", 64'(vld1), 64'd0);
    chk("reset_busy",  64'(busy1), 64'd0);
    chk("reset_cmd",   64'(cmd1), 64'd0);
    chk("reset_key",   64'(ak1), 64'd0);
    cycles(2);

    // Tap key 2
    q1.delete(); p = cyc;
    key_state = 4'b0100; key_pressed = 4'b0100;
    cycles(1); key_pressed = 4'b0;
    chk("tap_valid", 64'(vld1), 64'd1);
    chk("tap_cmd",   64'(cmd1), 64'(CMD_DOWN));
    chk("tap_key",   64'(ak1), 64'd2);
    cycles(1);
    chk("tap_valid_drop", 64'(vld1), 64'd0);
    cycles(1); key_state = 4'b0;
    cycles(4);
    chk("tap_busy_low", 64'(busy1), 64'd0);
    chk("tap_count", 64'(q1.size()), 64'd1);
    if (q1.size() > 0) chk("tap_when", 64'(q1[0].n), 64'(p + 1));

    // Hold key 0 for 30 cycles
    q1.delete(); p = cyc;
    key_state = 4'b0001; key_pressed = 4'b0001;
    cycles(1); key_pressed = 4'b0;
    cycles(29); key_state = 4'b0;
    cycles(10);
    chk("hold_count", 64'(q1.size()), 64'd5);
    if (q1.size() == 5) begin
      chk("hold_first",  64'(q1[0].n), 64'(p + 1));
      chk("hold_rpt1",   64'(q1[1].n), 64'(p + 11));
      chk("hold_rpt1_f", 64'(q1[1].rpt), 64'd1);
      chk("hold_rpt2",   64'(q1[2].n), 64'(p + 16));
      chk("hold_rpt4",   64'(q1[4].n), 64'(p + 26));
      chk("hold_rpt_cmd", 64'(q1[4].cmd), 64'(CMD_RIGHT));
    end

    // Simultaneous presses, then a press during WAIT_REL
    q1.delete();
    key_state = 4'b1010; key_pressed = 4'b1010;
    cycles(1); key_pressed = 4'b0; key_state = 4'b1000;
    chk("simul_key", 64'(ak1), 64'd1);
    chk("simul_cmd", 64'(cmd1), 64'(CMD_UP));
    cycles(2); key_state = 4'b1001; key_pressed = 4'b0001;
    cycles(1); key_pressed = 4'b0; key_state = 4'b1000;
    cycles(3); key_state = 4'b0;
    cycles(4);
    chk("simul_count", 64'(q1.size()), 64'd1);
    if (q1.size() > 0) chk("simul_xkey", 64'(q1[0].k), 64'd1);

    // Back-pressure on the first request
    q1.delete(); p = cyc; cmd_ready = 1'b0;
    key_state = 4'b0001; key_pressed = 4'b0001;
    cycles(1); key_pressed = 4'b0;
    for (int i = 0; i < 19; i++) begin
      chk("bp_valid", 64'(vld1), 64'd1);
      chk("bp_cmd", 64'(cmd1), 64'(CMD_RIGHT));
      cycles(1);
    end
    cmd_ready = 1'b1;
    cycles(15); key_state = 4'b0;
    cycles(8);
    chk("bp_count", 64'(q1.size()), 64'd3);
    if (q1.size() >= 2) begin
      chk("bp_first", 64'(q1[0].n), 64'(p + 20));
      chk("bp_rpt",   64'(q1[1].n), 64'(p + 30));
    end

    // Reset during HOLD with the key still held
    q1.delete();
    key_state = 4'b0010; key_pressed = 4'b0010;
    cycles(1); key_pressed = 4'b0;
    cycles(4); rst = 1'b1;
    cycles(1); rst = 1'b0;
    chk("rhold_valid", 64'(vld1), 64'd0);
    chk("rhold_busy",  64'(busy1), 64'd0);
    chk("rhold_cmd",   64'(cmd1), 64'd0);
    chk("rhold_key",   64'(ak1), 64'd0);
    cycles(20);
    chk("rhold_quiet", 64'(q1.size()), 64'd1);
    key_state = 4'b0;
    cycles(3);

    // Reset during SEND with a pending request
    q1.delete(); cmd_ready = 1'b0;
    key_state = 4'b0100; key_pressed = 4'b0100;
    cycles(1); key_pressed = 4'b0;
    chk("rsend_pending", 64'(vld1), 64'd1);
    cycles(2); rst = 1'b1;
    cycles(1); rst = 1'b0;
    chk("rsend_valid", 64'(vld1), 64'd0);
    chk("rsend_rpt",   64'(rpt1), 64'd0);
    chk("rsend_cmd",   64'(cmd1), 64'd0);
    cmd_ready = 1'b1;
    cycles(15);
    chk("rsend_quiet", 64'(q1.size()), 64'd0);
    key_state = 4'b0;
    cycles(3);

    // Repeat disabled: one transfer for a long hold of key 3
    q0.delete();
    key_state = 4'b1000; key_pressed = 4'b1000;
    cycles(1); key_pressed = 4'b0;
    cycles(49); key_state = 4'b0;
    cycles(5);
    chk("norpt_count", 64'(q0.size()), 64'd1);
    if (q0.size() > 0) chk("norpt_cmd", 64'(q0[0].cmd), 64'(CMD_LEFT));

    // Random key activity, back-pressure and occasional reset
    ks_prev = key_state;
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] ks;
      ks = ks_prev;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 24) == 0) ks[b] = ~ks[b];
      key_pressed = ks & ~ks_prev;
      if ($urandom_range(0, 49) == 0) key_pressed[$urandom_range(0, 3)] = 1'b1;
      key_state = ks;
      ks_prev = ks;
      cmd_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      cycles(1);
    end
    rst = 1'b0; key_pressed = 4'b0; key_state = 4'b0; cmd_ready = 1'b1;
    cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
